// File: rtl/vip_bch_syndrome_calc_if.sv
// rtl/vip_bch_syndrome_calc_if.sv - bit-serial codeword in / syndrome result out bundle
//
// in_valid/in_ready/in_bit/in_last : received codeword, MSB coefficient first
// out_valid/out_ready              : result handshake
// out_syndromes                    : S_j at [(j-1)*M_P +: M_P], j = 1..2*T_P
// out_err/out_length/out_len_err   : any-nonzero flag, bit count, overlength flag
interface vip_bch_syndrome_calc_if #(
    parameter int M_P = 13,
    parameter int T_P = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_bit;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*T_P*M_P-1:0]     out_syndromes;
    logic                     out_err;
    logic [M_P:0]             out_length;
    logic                     out_len_err;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_syndromes, out_err, out_length, out_len_err
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_syndromes, out_err, out_length, out_len_err
    );
endinterface

// File: rtl/vip_bch_syndrome_calc.sv
// rtl/vip_bch_syndrome_calc.sv - BCH receive-side syndrome accumulator (Horner, GF(2^m))
//
// clk, rst_n : clock and asynchronous active-low reset
// bus        : slave side of vip_bch_syndrome_calc_if (bit input stream, result output)
module vip_bch_syndrome_calc #(
    parameter int           M_P         = 13,
    parameter int           T_P         = 4,
    parameter logic [M_P:0] PRIM_POLY_P = 14'h201B,
    parameter int           N_P         = 2**M_P - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vip_bch_syndrome_calc_if.slave   bus
);
    localparam int           NS      = 2 * T_P;
    localparam int           W       = NS * M_P;
    localparam logic [M_P:0] CNT_MAX = {1'b1, {M_P{1'b0}}};
    localparam logic [M_P:0] N_V     = (M_P+1)'(N_P);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    // Column i of the matrix is alpha^j * x^i, so a constant multiply by alpha^j
    // is the XOR of the columns selected by the set bits of the operand.
    function automatic logic [M_P*M_P-1:0] build_mat(input int jj);
        logic [M_P*M_P-1:0] mat;
        logic [M_P-1:0]     v;
        mat = '0;
        for (int i = 0; i < M_P; i++) begin
            v = '0;
            v[i] = 1'b1;
            for (int k = 0; k < jj; k++) begin
                v = v[M_P-1] ? ({v[M_P-2:0], 1'b0} ^ PRIM_POLY_P[M_P-1:0])
                             :  {v[M_P-2:0], 1'b0};
            end
            mat[i*M_P +: M_P] = v;
        end
        return mat;
    endfunction

    function automatic logic [M_P-1:0] mat_mul(input logic [M_P*M_P-1:0] mat,
                                               input logic [M_P-1:0]     a);
        logic [M_P-1:0] p;
        p = '0;
        for (int i = 0; i < M_P; i++) begin
            if (a[i]) p = p ^ mat[i*M_P +: M_P];
        end
        return p;
    endfunction

    logic [0:0]   state_q;
    logic [W-1:0] syn_q;
    logic [W-1:0] syn_mul;
    logic [W-1:0] syn_d;
    logic [M_P:0] cnt_q;
    logic         accept;

    for (genvar g = 0; g < NS; g++) begin : g_syn
        localparam logic [M_P*M_P-1:0] MAT = build_mat(g + 1);
        assign syn_mul[g*M_P +: M_P] = mat_mul(MAT, syn_q[g*M_P +: M_P]);
    end

    // Horner step: S_j <- S_j * alpha^j + r_k, with r_k injected in bit 0 of every lane
    always_comb begin
        syn_d = syn_mul;
        for (int g = 0; g < NS; g++) begin
            syn_d[g*M_P] = syn_mul[g*M_P] ^ bus.in_bit;
        end
    end

    assign accept = bus.in_valid && (state_q == ST_ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            syn_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q == ST_ACCUM) begin
            if (accept) begin
                syn_q <= syn_d;
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                if (bus.in_last) state_q <= ST_DONE;
            end
        end else if (bus.out_ready) begin
            // Clearing here gives exactly one bubble cycle before the next codeword
            state_q <= ST_ACCUM;
            syn_q   <= '0;
            cnt_q   <= '0;
        end
    end

    // Outputs are pure functions of registered state, so nothing on the input
    // side reaches in_ready/out_valid combinationally.
    assign bus.in_ready      = (state_q == ST_ACCUM);
    assign bus.out_valid     = (state_q == ST_DONE);
    assign bus.out_syndromes = syn_q;
    assign bus.out_err       = |syn_q;
    assign bus.out_length    = cnt_q;
    assign bus.out_len_err   = (cnt_q > N_V);
endmodule

// File: doc/vip_bch_syndrome_calc.md
Name: vip_bch_syndrome_calc

Overview:
- Receive-side front end of the BCH decoder. Accepts a received codeword serially, one bit per handshake, most significant polynomial coefficient first.
- Accumulates the 2t syndromes S_j = r(alpha^j), j = 1..2t, over GF(2^m) by Horner iteration.
- Presents the syndromes plus an error flag and the codeword length to the downstream error-locator stage over a valid/ready interface.

Parameters:
- M_P, 13, Galois field order m; GF(2^m) elements are M_P bits wide.
- T_P, 4, correctable bit errors t; 2*T_P syndromes are produced.
- PRIM_POLY_P, 14'h201B, primitive polynomial of GF(2^m), M_P+1 bits, bit M_P set.
- N_P, 2**M_P-1, maximum codeword length n in bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  received bit valid.
- in_ready  out  1  block accepts a bit.
- in_bit  in  1  received coefficient; first accepted bit is the highest degree.
- in_last  in  1  marks the final bit of the codeword.
- out_valid  out  1  syndrome result valid.
- out_ready  in  1  downstream accepts the result.
- out_syndromes  out  2*T_P*M_P  S_j packed at [(j-1)*M_P +: M_P], j = 1..2*T_P.
- out_err  out  1  any syndrome nonzero.
- out_length  out  M_P+1  number of bits accepted, saturating at 2**M_P.
- out_len_err  out  1  out_length > N_P.

Behaviour:
- Reset:
  - state = ST_ACCUM; all syndrome accumulators and the bit counter are 0.
  - in_ready = 1, out_valid = 0, out_syndromes = 0, out_err = 0, out_length = 0, out_len_err = 0.
- State ST_ACCUM:
  - in_ready = 1, out_valid = 0.
  - On each in_valid && in_ready, for every j: S_j <= (S_j * alpha^j) xor {0.., in_bit}.
  - The multiplication by alpha^j is a constant GF(2^m) multiply reduced by PRIM_POLY_P. Its constant matrix is derived at elaboration by j repeated multiply-by-x steps.
  - The counter increments, saturating at 2**M_P.
- Transition to ST_DONE: when the handshake carries in_last = 1, the final update is applied and the state moves to ST_DONE on the next edge.
  - Latency: last bit accepted on edge c, out_valid = 1 from edge c+1.
- State ST_DONE:
  - in_ready = 0, out_valid = 1.
  - All outputs are held stable until out_ready.
  - out_err = OR of all syndrome bits; out_len_err = (counter > N_P).
- Return to ST_ACCUM: on out_valid && out_ready, the state returns to ST_ACCUM, accumulators and counter clear to 0, and out_valid drops the next cycle.
  - The first bit of the next codeword can be accepted on the cycle after the result handshake (one bubble cycle).
- in_valid low in ST_ACCUM: accumulators hold; gaps of any length are legal.
- in_last on the very first bit: a 1-bit codeword is legal. Result: all S_j = in_bit, out_length = 1.
- Counter saturation: no wrap-around. out_length stays at 2**M_P and out_len_err = 1. Syndromes continue to update for every accepted bit.
- Output values: out_syndromes, out_err, out_length and out_len_err are registered. They are meaningful only while out_valid = 1.
- Reset asserted mid-codeword or in ST_DONE: immediate return to reset values; any partial codeword or pending result is discarded.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

Test Plan (M_P=4, T_P=2, PRIM_POLY_P=5'b10011, N_P=15):
- 15 zero bits, last on the 15th -> out_syndromes all 0x0, out_err=0, out_length=15, out_len_err=0, out_valid one cycle after the last accept.
- Generator g(x)=x^8+x^7+x^6+x^4+1 as a codeword (6 zeros then 1,1,1,0,1,0,0,0,1) -> all four syndromes 0x0, out_err=0.
- r(x)=x (13 zeros, 1, 0) -> S1=0x2, S2=0x4, S3=0x8, S4=0x3, out_err=1.
- r(x)=1 with random in_valid gaps, out_ready held low 5 cycles -> S1..S4=0x1. in_ready=0 and outputs stable for all 5 cycles; the next codeword is accepted after the result handshake.
- 17 bits, all zero except the last bit = 1 -> out_length=16 (saturated), out_len_err=1, S1..S4=0x1.
- rst_n pulsed low after 7 bits of a codeword -> all outputs at reset values. A following 15-bit codeword r(x)=x yields exactly the values of scenario 3.
